// File: rtl/pll_rst_seq.sv
// Reset sequencer for the PLL-clocked pipeline: qualifies pll_lock, releases
// staged active-low resets in index order and re-asserts them on lock loss or soft reset.
module pll_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP          = 16,
  parameter int LOSS_FILTER        = 4,
  parameter int CNT_W              = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_lock,
  input  logic                  soft_rst,
  output logic [NUM_STAGES-1:0] rst_stage_n,
  output logic                  sys_ready,
  output logic [CNT_W-1:0]      lock_loss_cnt,
  output logic [2:0]            seq_state
);

  localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);
  localparam int IDX_W  = $clog2(NUM_STAGES + 1);

  localparam logic [STAB_W-1:0]     STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [LOSS_W-1:0]     LOSS_LAST  = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [IDX_W-1:0]      STAGE_LAST = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0_ON  = NUM_STAGES'(1'b1);
  localparam logic [NUM_STAGES-1:0] STAGES_OFF = {NUM_STAGES{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
  localparam bit                    SINGLE_STAGE = (NUM_STAGES == 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  logic [1:0]            sync_q;
  logic                  lock_s;
  state_e                state_q, state_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic [LOSS_W-1:0]     loss_cnt_q, loss_cnt_d;
  logic [NUM_STAGES-1:0] rst_stage_q, rst_stage_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      loss_evt_q, loss_evt_d;
  logic                  loss_active_s;
  logic                  loss_trip_s;
  logic                  soft_take_s;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

  // Sequencer state, counters and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= {STAB_W{1'b0}};
      gap_cnt_q   <= {GAP_W{1'b0}};
      stage_idx_q <= {IDX_W{1'b0}};
      loss_cnt_q  <= {LOSS_W{1'b0}};
      rst_stage_q <= STAGES_OFF;
      ready_q     <= 1'b0;
      loss_evt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      loss_cnt_q  <= loss_cnt_d;
      rst_stage_q <= rst_stage_d;
      ready_q     <= ready_d;
      loss_evt_q  <= loss_evt_d;
    end
  end

  // Next-state logic; loss trip and soft reset override the per-state result
  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    loss_cnt_d  = loss_cnt_q;
    rst_stage_d = rst_stage_q;
    ready_d     = ready_q;
    loss_evt_d  = loss_evt_q;

    loss_active_s = (state_q == RELEASE) || (state_q == RUN);
    loss_trip_s   = loss_active_s && !lock_s && (loss_cnt_q == LOSS_LAST);
    soft_take_s   = soft_rst && ((state_q == STABLE) || loss_active_s);

    if (!loss_active_s || lock_s || loss_trip_s) begin
      loss_cnt_d = {LOSS_W{1'b0}};
    end else begin
      loss_cnt_d = loss_cnt_q + LOSS_W'(1'b1);
    end

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = STABLE;
          stab_cnt_d = {STAB_W{1'b0}};
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = {STAB_W{1'b0}};
        end else if (stab_cnt_q == STAB_LAST) begin
          rst_stage_d = STAGE0_ON;
          gap_cnt_d   = {GAP_W{1'b0}};
          stage_idx_d = IDX_W'(1'b1);
          if (SINGLE_STAGE) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1'b1);
        end
      end
      RELEASE: begin
        if (gap_cnt_q == GAP_LAST) begin
          // OR-in the next bit so stages can only ever release in index order
          rst_stage_d = rst_stage_q | (STAGE0_ON << stage_idx_q);
          gap_cnt_d   = {GAP_W{1'b0}};
          stage_idx_d = stage_idx_q + IDX_W'(1'b1);
          if (stage_idx_q == STAGE_LAST) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1'b1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      FAULT: begin
        state_d = WAIT_LOCK;
      end
      default: begin
        state_d     = WAIT_LOCK;
        rst_stage_d = STAGES_OFF;
        ready_d     = 1'b0;
      end
    endcase

    if (loss_trip_s) begin
      state_d     = FAULT;
      rst_stage_d = STAGES_OFF;
      ready_d     = 1'b0;
      stab_cnt_d  = {STAB_W{1'b0}};
      gap_cnt_d   = {GAP_W{1'b0}};
      stage_idx_d = {IDX_W{1'b0}};
      loss_evt_d  = (loss_evt_q == CNT_MAX) ? loss_evt_q : loss_evt_q + CNT_W'(1'b1);
    end else if (soft_take_s) begin
      state_d     = WAIT_LOCK;
      rst_stage_d = STAGES_OFF;
      ready_d     = 1'b0;
      stab_cnt_d  = {STAB_W{1'b0}};
      gap_cnt_d   = {GAP_W{1'b0}};
      stage_idx_d = {IDX_W{1'b0}};
    end else begin
      loss_evt_d = loss_evt_d;
    end
  end

  assign rst_stage_n   = rst_stage_q;
  assign sys_ready     = ready_q;
  assign lock_loss_cnt = loss_evt_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus random lock/soft-reset traffic,
// checked against a time-based reference model of the release schedule.
module tb_pll_rst_seq;

  localparam int L  = 8;
  localparam int N  = 3;
  localparam int G  = 4;
  localparam int F  = 4;
  localparam int CW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          pll_lock;
  logic          soft_rst;
  logic [N-1:0]  rst_stage_n;
  logic          sys_ready;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0]    seq_state;

  int checks = 0;
  int errors = 0;

  // Reference model: sequence start edge plus arithmetic on elapsed edges
  bit m_p1, m_p2, m_act, m_fault;
  int m_e, m_t0, m_loss, m_cnt;

  pll_rst_seq #(
    .LOCK_STABLE_CYCLES(L), .NUM_STAGES(N), .STAGE_GAP(G),
    .LOSS_FILTER(F), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
    .soft_rst(soft_rst), .rst_stage_n(rst_stage_n), .sys_ready(sys_ready),
    .lock_loss_cnt(lock_loss_cnt), .seq_state(seq_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_p1 = 1'b0; m_p2 = 1'b0; m_act = 1'b0; m_fault = 1'b0;
    m_e = 0; m_t0 = 0; m_loss = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit ls;
    int el;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    m_e++;
    ls = m_p2;
    m_p2 = m_p1;
    m_p1 = pll_lock;
    if (m_fault) begin
      m_fault = 1'b0;
    end else if (!m_act) begin
      if (ls) begin
        m_act = 1'b1;
        m_t0 = m_e;
        m_loss = 0;
      end
    end else begin
      el = m_e - m_t0;
      if (el <= L) begin
        if (soft_rst || !ls) m_act = 1'b0;
      end else begin
        m_loss = ls ? 0 : m_loss + 1;
        if (m_loss == F) begin
          m_act = 1'b0;
          m_fault = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else if (soft_rst) begin
          m_act = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [N+CW+3:0] exp_vec();
    logic [N-1:0] r;
    logic rdy;
    logic [2:0] st;
    logic [CW-1:0] c;
    int el;
    r = '0;
    rdy = 1'b0;
    el = m_e - m_t0;
    if (m_fault) st = 3'd4;
    else if (!m_act) st = 3'd0;
    else if (el < L) st = 3'd1;
    else begin
      for (int k = 0; k < N; k++) if (el >= L + k * G) r[k] = 1'b1;
      rdy = &r;
      st = rdy ? 3'd3 : 3'd2;
    end
    c = CW'(m_cnt);
    return {r, rdy, c, st};
  endfunction

  function automatic logic [N+CW+3:0] dut_vec();
    return {rst_stage_n, sys_ready, lock_loss_cnt, seq_state};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; pll_lock = 1'b0; soft_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    pll_lock = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_model e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
      if (e == 10 || e == 11 || e == 15 || e == 18 || e == 19) begin
        checks++;
        if (rst_stage_n !== ((e == 10) ? 3'b000 : (e == 11) ? 3'b001 :
                             (e == 19) ? 3'b111 : 3'b011)) begin
          errors++;
          $display("FAIL clean_stage e%0d: got %b", e, rst_stage_n);
        end
      end
    end
    checks++;
    if (sys_ready !== 1'b1 || seq_state !== 3'd3) begin
      errors++;
      $display("FAIL clean_run: ready %b state %0d expected 1/3", sys_ready, seq_state);
    end
  endtask

  task automatic test_glitch();
    pll_lock = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) pll_lock = 1'b1;
      step();
      checks++;
      if (rst_stage_n !== 3'b111 || sys_ready !== 1'b1 || lock_loss_cnt !== 8'd0 ||
          dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL loss_model e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
      if (e == 5 || e == 6 || e == 7) begin
        checks++;
        if ((e == 5 && rst_stage_n !== 3'b111) ||
            (e == 6 && (rst_stage_n !== 3'b000 || sys_ready !== 1'b0 ||
                        lock_loss_cnt !== 8'd1 || seq_state !== 3'd4)) ||
            (e == 7 && seq_state !== 3'd0)) begin
          errors++;
          $display("FAIL loss_e%0d: got %h", e, dut_vec());
        end
      end
    end
    pll_lock = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL loss_relock e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rst_stage_n !== 3'b111 || sys_ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock_done: got %b/%b expected 111/1", rst_stage_n, sys_ready);
    end
  endtask

  task automatic test_soft_reset();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL soft_model e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rst_stage_n !== 3'b011) begin
      errors++;
      $display("FAIL soft_setup: got %b expected 011", rst_stage_n);
    end
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    checks++;
    if (dut_vec() !== {3'b000, 1'b0, 8'd1, 3'd0}) begin
      errors++;
      $display("FAIL soft_in_release: got %h", dut_vec());
    end
    for (int e = 1; e <= 17; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec() || (e == 8 && rst_stage_n !== 3'b000) ||
          (e == 9 && rst_stage_n !== 3'b001) || (e == 17 && rst_stage_n !== 3'b111)) begin
        errors++;
        $display("FAIL soft_reseq e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_unstable();
    pll_lock = 1'b0;
    repeat (10) step();
    pll_lock = 1'b1;
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec() || (e < 11 && rst_stage_n !== 3'b000) ||
          (e == 11 && rst_stage_n !== 3'b001)) begin
        errors++;
        $display("FAIL unstable e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        pll_lock = ~pll_lock;
        run = pll_lock ? $urandom_range(1, 40) : $urandom_range(1, 8);
      end
      run--;
      soft_rst = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random i%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    soft_rst = 1'b0;
  endtask

  task automatic test_saturation_async();
    for (int ev = 0; ev < 260; ev++) begin
      for (int e = 0; e < 24; e++) begin
        pll_lock = (e < 14);
        step();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL sat ev%0d e%0d: got %h expected %h", ev, e, dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got %0d expected 255", lock_loss_cnt);
    end
    pll_lock = 1'b1;
    repeat (16) step();
    checks++;
    if (rst_stage_n !== 3'b011 || seq_state !== 3'd2) begin
      errors++;
      $display("FAIL async_setup: got %b state %0d expected 011/2", rst_stage_n, seq_state);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec() || (e == 11 && rst_stage_n !== 3'b001)) begin
        errors++;
        $display("FAIL async_reseq e%0d: got %h expected %h", e, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_lock_loss();
    test_soft_reset();
    test_unstable();
    test_random();
    test_saturation_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
